// File: rtl/inv_aes_pkg.sv
// Shared types, constants and GF(2^8) / column helpers for the inverse AES
// AddRoundKey + column-serial InvMixColumns stage.
package inv_aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_state_t;

  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } colseq_state_e;

  // Column idx of a state; column 0 lives in the top word [127:96].
  function automatic aes_word_t col_get(input aes_state_t s, input logic [1:0] idx);
    return s[(NUM_COLS - 1 - int'(idx)) * 32 +: 32];
  endfunction

  // Returns s with column idx replaced by w.
  function automatic aes_state_t col_put(input aes_state_t s, input logic [1:0] idx,
                                         input aes_word_t w);
    aes_state_t r;
    r = s;
    r[(NUM_COLS - 1 - int'(idx)) * 32 +: 32] = w;
    return r;
  endfunction

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using a precomputed doubling chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/inv_aes_mixw.sv
// One-column InvMixColumns: purely combinational GF(2^8) matrix multiply.
// Row 0 of the column is the top byte [31:24].
module inv_aes_mixw
  import inv_aes_pkg::*;
(
  input  aes_word_t w_i,
  output aes_word_t mixw_o
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = w_i[31:24];
  assign w_a1 = w_i[23:16];
  assign w_a2 = w_i[15:8];
  assign w_a3 = w_i[7:0];

  // Circulant inverse matrix rows {0e,0b,0d,09} rotated per output row.
  assign mixw_o[31:24] = gmul(w_a0, 4'he) ^ gmul(w_a1, 4'hb) ^ gmul(w_a2, 4'hd) ^ gmul(w_a3, 4'h9);
  assign mixw_o[23:16] = gmul(w_a0, 4'h9) ^ gmul(w_a1, 4'he) ^ gmul(w_a2, 4'hb) ^ gmul(w_a3, 4'hd);
  assign mixw_o[15:8]  = gmul(w_a0, 4'hd) ^ gmul(w_a1, 4'h9) ^ gmul(w_a2, 4'he) ^ gmul(w_a3, 4'hb);
  assign mixw_o[7:0]   = gmul(w_a0, 4'hb) ^ gmul(w_a1, 4'hd) ^ gmul(w_a2, 4'h9) ^ gmul(w_a3, 4'he);

endmodule

// File: rtl/inv_aes_ark_colseq.sv
// Inverse-cipher round stage: AddRoundKey on accept, then InvMixColumns
// applied MIX_LANES columns per cycle, result held until the consumer pops it.
// Optional feature macro: INV_ARK_LAST_ROUND_EN adds last_i; a block accepted
// with last_i=1 skips the mix pass (AddRoundKey only).
module inv_aes_ark_colseq
  import inv_aes_pkg::*;
#(
  parameter int MIX_LANES = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] state_o,
  output logic         busy_o
`ifdef INV_ARK_LAST_ROUND_EN
  ,
  input  logic         last_i
`endif
);

  if (MIX_LANES != 1 && MIX_LANES != 2 && MIX_LANES != 4) begin : g_bad_lanes
    $fatal(1, "inv_aes_ark_colseq: MIX_LANES must be 1, 2 or 4");
  end

  // Column group that finishes the mix pass, and the per-cycle column step.
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - MIX_LANES);
  localparam logic [1:0] COL_STEP = 2'(MIX_LANES);

  colseq_state_e r_state, w_state_next;
  logic [1:0]    r_col, w_col_next;
  aes_state_t    r_buf, w_buf_next;

  aes_word_t     w_lane_in  [MIX_LANES];
  aes_word_t     w_lane_out [MIX_LANES];

  // Lane l mixes column r_col+l of the buffer.
  for (genvar l = 0; l < MIX_LANES; l++) begin : g_lane
    assign w_lane_in[l] = col_get(r_buf, r_col + 2'(l));
    inv_aes_mixw u_mixw (
      .w_i    (w_lane_in[l]),
      .mixw_o (w_lane_out[l])
    );
  end

  // Next-state, column counter and buffer update.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    w_state_next = r_state;
    w_col_next   = r_col;
    w_buf_next   = r_buf;
    unique case (r_state)
      IDLE: begin
        // Inputs are sampled only on an accepted handshake, so idle garbage never reaches r_buf.
        if (in_valid_i) begin
          w_buf_next   = state_i ^ key_i;
          w_col_next   = '0;
          w_state_next = MIX;
`ifdef INV_ARK_LAST_ROUND_EN
          if (last_i) w_state_next = DONE;
`endif
        end
      end
      MIX: begin
        for (int l = 0; l < MIX_LANES; l++) begin
          w_buf_next = col_put(w_buf_next, r_col + 2'(l), w_lane_out[l]);
        end
        w_col_next = r_col + COL_STEP;
        if (r_col == LAST_COL) w_state_next = DONE;
      end
      DONE: begin
        if (out_ready_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register; reset discards any partly mixed block.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      r_state <= IDLE;
      r_col   <= '0;
      // NOTE: the data buffer is reset too, because state_o must read zero after reset.
      r_buf   <= '0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_buf   <= w_buf_next;
    end
  end

  assign in_ready_o  = (r_state == IDLE) & ~rst_i;
  assign out_valid_o = (r_state == DONE) & ~rst_i;
  assign busy_o      = (r_state != IDLE) & ~rst_i;
  assign state_o     = rst_i ? '0 : r_buf;

endmodule

// File: tb/tb_inv_aes_ark_colseq.sv
// Scoreboard bench for inv_aes_ark_colseq. Expected blocks are pushed when a
// handshake is seen and compared when the stage pops a result.
// Define INV_ARK_LAST_ROUND_EN to also exercise the last-round bypass.
module tb_inv_aes_ark_colseq #(
  parameter int MIX_LANES = 1
);

  localparam int MIX_LAT = 1 + 4 / MIX_LANES;
  localparam logic [127:0] V1_IN  = 128'h5f72641557f5bc92f7be3b291db9f91a;
  localparam logic [127:0] V1_EXP = 128'h6353e08c0960e104cd70b751bacad0e7;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] state_i;
  logic [127:0] key_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] state_o;
  logic         busy_o;
  logic         last_i;

  always #5 clk = ~clk;

  inv_aes_ark_colseq #(.MIX_LANES(MIX_LANES)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .state_i     (state_i),
    .key_i       (key_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .state_o     (state_o),
    .busy_o      (busy_o)
`ifdef INV_ARK_LAST_ROUND_EN
    ,
    .last_i      (last_i)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Independent reference: shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix_model(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   m [4];
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        logic [7:0] acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gf_mul(a[k], m[(k - row + 4) % 4]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  typedef struct {
    logic [127:0] exp;
    int           acc_cyc;
    int           lat;
  } sb_t;

  sb_t          sb[$];
  int           cyc = 0;
  int           n_acc = 0;
  int           last_acc_cyc = 0;
  int           vld_cyc = 0;
  logic         prev_vld = 1'b0;
  logic [127:0] drv_exp = '0;
  int           drv_lat = MIX_LAT;

  always @(posedge clk) cyc++;

  // Monitor: handshakes are evaluated mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_i) begin
      sb.delete();
      prev_vld = 1'b0;
    end else begin
      if (in_valid_i && in_ready_o) begin
        sb_t e;
        e.exp = drv_exp;
        e.acc_cyc = cyc;
        e.lat = drv_lat;
        sb.push_back(e);
        n_acc++;
        last_acc_cyc = cyc;
      end
      if (out_valid_o && !prev_vld) vld_cyc = cyc;
      prev_vld = out_valid_o;
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          check("spurious_out", 128'd1, 128'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("state_o", state_o, e.exp);
          check("latency", 128'(vld_cyc - e.acc_cyc), 128'(e.lat));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic last,
                      input logic [127:0] exp);
    int start;
    int b;
    start      = n_acc;
    b          = 0;
    state_i    = s;
    key_i      = k;
    last_i     = last;
    drv_exp    = exp;
    drv_lat    = last ? 1 : MIX_LAT;
    in_valid_i = 1'b1;
    do begin
      tick();
      b++;
    end while (n_acc == start && b < 200);
    if (n_acc == start) check("accept_timeout", 128'd0, 128'd1);
    in_valid_i = 1'b0;
    state_i    = {4{$urandom}};
    key_i      = {4{$urandom}};
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() != 0 && b < 500) begin
      tick();
      b++;
    end
    if (sb.size() != 0) check("drain_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s, k, held;
    int b;
    int first_acc;

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    last_i      = 1'b0;
    state_i     = '0;
    key_i       = '0;
    repeat (3) tick();
    in_valid_i  = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready_o), 128'd0);
    check("rst_out_valid", 128'(out_valid_o), 128'd0);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_state_o", state_o, 128'd0);
    tick();
    in_valid_i = 1'b0;
    rst_i      = 1'b0;
    @(negedge clk);
    check("idle_ready", 128'(in_ready_o), 128'd1);
    tick();

    // Known vector with zero key, then key == state and an all-ones key.
    send(V1_IN, '0, 1'b0, V1_EXP);
    drain();
    send(V1_IN, V1_IN, 1'b0, '0);
    s = 128'ha08dffea3c15b27e9a0c4d81f6e53719;
    k = '1;
    send(s, k, 1'b0, inv_mix_model(s ^ k));
    drain();

    // Hold the result in DONE for 10 cycles while poking in_valid_i.
    out_ready_i = 1'b0;
    s = {4{$urandom}};
    k = {4{$urandom}};
    send(s, k, 1'b0, inv_mix_model(s ^ k));
    b = 0;
    while (!out_valid_o && b < 50) begin
      tick();
      b++;
    end
    @(negedge clk);
    held = state_o;
    check("stall_reach_done", 128'(out_valid_o), 128'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      in_valid_i = ~in_valid_i;
      state_i    = {4{$urandom}};
      @(negedge clk);
      check("stall_valid", 128'(out_valid_o), 128'd1);
      check("stall_state", state_o, held);
      check("stall_ready", 128'(in_ready_o), 128'd0);
    end
    tick();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("pop_busy", 128'(busy_o), 128'd0);
    check("pop_ready", 128'(in_ready_o), 128'd1);
    tick();

    // Reset in the cycle that mixes column 2; the block must vanish.
    send(V1_IN, '0, 1'b0, V1_EXP);
    repeat (2 / MIX_LANES) tick();
    check("mid_busy", 128'(busy_o), 128'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 128'(out_valid_o), 128'd0);
    check("mid_rst_state", state_o, 128'd0);
    check("mid_rst_busy", 128'(busy_o), 128'd0);
    tick();
    send(V1_IN, '0, 1'b0, V1_EXP);
    drain();

    // 100 back-to-back random blocks with the consumer always ready.
    first_acc = 0;
    for (int i = 0; i < 100; i++) begin
      s = {4{$urandom}};
      k = {4{$urandom}};
      send(s, k, 1'b0, inv_mix_model(s ^ k));
      if (i == 0) first_acc = last_acc_cyc;
    end
    check("throughput", 128'(last_acc_cyc - first_acc), 128'(99 * (2 + 4 / MIX_LANES)));
    drain();

`ifdef INV_ARK_LAST_ROUND_EN
    send(128'h000102030405060708090a0b0c0d0e0f, 128'h0f0e0d0c0b0a09080706050403020100,
         1'b1, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f);
    drain();
    send(V1_IN, '0, 1'b0, V1_EXP);
    drain();
`endif

    repeat (3) tick();
    check("sb_empty", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
